// File: rtl/line_buffer_kxk_stream.sv
// line_buffer_kxk_stream: KxK sliding-window generator for a raster pixel stream.
// K-1 line memories feed the column vector of a KxK window shift register; a
// window is registered onto m_* whenever the accepted pixel completes one on the
// stride grid. Ready/valid on both sides; start_frame latches cfg or aborts.
// Optional feature macro: LB_STALL_CNT_EN (builds the backpressure stall counter).
module line_buffer_kxk_stream #(
  parameter int DATA_W    = 8,
  parameter int KSIZE     = 3,
  parameter int MAX_WIDTH = 224
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start_frame,
  input  logic [15:0]                     cfg_width,
  input  logic [15:0]                     cfg_height,
  input  logic [1:0]                      cfg_stride,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   m_window,
  output logic [15:0]                     m_row,
  output logic [15:0]                     m_col,
  output logic                            frame_done,
  output logic                            cfg_err,
  output logic [31:0]                     stall_cnt
);

  localparam int          AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int          NL   = KSIZE - 1;
  localparam logic [15:0] K_M1 = 16'(KSIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0] r_width;
  logic [15:0] r_height;
  logic [1:0]  r_stride;
  logic [15:0] r_row;
  logic [15:0] r_col;
  logic [1:0]  r_row_ph;   // rows since K-1, modulo stride
  logic [1:0]  r_col_ph;   // cols since K-1, modulo stride

  logic [DATA_W-1:0] r_line [NL][MAX_WIDTH];  // line 0 = oldest row
  logic [DATA_W-1:0] r_win  [KSIZE][KSIZE];   // [row][col], col 0 = leftmost

  logic                           r_m_valid;
  logic [KSIZE*KSIZE*DATA_W-1:0]  r_m_window;
  logic [15:0]                    r_m_row;
  logic [15:0]                    r_m_col;
  logic                           r_frame_done;
  logic                           r_cfg_err;

  logic                           w_cfg_ok;
  logic                           w_accept;
  logic                           w_last_col;
  logic                           w_last_px;
  logic                           w_emit;
  logic                           w_start_ok;
  logic                           w_cfg_err_p;
  logic                           w_done_p;
  logic [AW-1:0]                  w_col_idx;
  logic [DATA_W-1:0]              w_colv     [KSIZE];
  logic [DATA_W-1:0]              w_win_next [KSIZE][KSIZE];
  logic [KSIZE*KSIZE*DATA_W-1:0]  w_win_flat;

  assign w_cfg_ok   = (cfg_width >= 16'(KSIZE)) && (cfg_width <= 16'(MAX_WIDTH)) &&
                      (cfg_height >= 16'(KSIZE)) && (cfg_stride != 2'd0);
  assign s_ready    = (r_state == ST_RUN) && (!r_m_valid || m_ready);
  // start_frame takes precedence over a pixel offered in the same cycle
  assign w_accept   = s_valid && s_ready && !start_frame;
  assign w_last_col = (r_col == (r_width - 16'd1));
  assign w_last_px  = w_last_col && (r_row == (r_height - 16'd1));
  assign w_emit     = (r_row >= K_M1) && (r_col >= K_M1) && (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
  assign w_col_idx  = r_col[AW-1:0];

  assign m_valid    = r_m_valid;
  assign m_window   = r_m_window;
  assign m_row      = r_m_row;
  assign m_col      = r_m_col;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

  // Column vector (read-before-write of the line memories) and next window contents
  always_comb begin
    for (int j = 0; j < NL; j++) begin
      w_colv[j] = r_line[j][w_col_idx];
    end
    w_colv[KSIZE-1] = s_data;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
      w_win_next[r][KSIZE-1] = w_colv[r];
    end
    w_win_flat = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        w_win_flat[(r*KSIZE+c)*DATA_W +: DATA_W] = w_win_next[r][c];
      end
    end
  end

  // FSM next-state and one-cycle event decode
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_cfg_err_p  = 1'b0;
    w_done_p     = 1'b0;
    if (start_frame) begin
      if (w_cfg_ok) begin
        w_state_next = ST_RUN;
        w_start_ok   = 1'b1;
      end else begin
        w_state_next = ST_IDLE;
        w_cfg_err_p  = 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_RUN: begin
          if (w_accept && w_last_px) begin
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!r_m_valid || m_ready) begin
            w_state_next = ST_IDLE;
            w_done_p     = 1'b1;
          end else begin
            w_state_next = ST_DRAIN;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched configuration plus raster position and stride-phase counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_width  <= 16'd0;
      r_height <= 16'd0;
      r_stride <= 2'd0;
      r_row    <= 16'd0;
      r_col    <= 16'd0;
      r_row_ph <= 2'd0;
      r_col_ph <= 2'd0;
    end else if (start_frame) begin
      if (w_start_ok) begin
        r_width  <= cfg_width;
        r_height <= cfg_height;
        r_stride <= cfg_stride;
      end
      r_row    <= 16'd0;
      r_col    <= 16'd0;
      r_row_ph <= 2'd0;
      r_col_ph <= 2'd0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col    <= 16'd0;
        r_col_ph <= 2'd0;
        r_row    <= r_row + 16'd1;
        if (r_row >= K_M1) begin
          r_row_ph <= (r_row_ph == (r_stride - 2'd1)) ? 2'd0 : (r_row_ph + 2'd1);
        end
      end else begin
        r_col <= r_col + 16'd1;
        if (r_col >= K_M1) begin
          r_col_ph <= (r_col_ph == (r_stride - 2'd1)) ? 2'd0 : (r_col_ph + 2'd1);
        end
      end
    end
  end

  // Line memories shift one row older and the window shifts left on each accepted pixel
  always_ff @(posedge clock) begin
    if (w_accept && !reset) begin
      for (int j = 0; j < NL - 1; j++) begin
        r_line[j][w_col_idx] <= r_line[j+1][w_col_idx];
      end
      r_line[NL-1][w_col_idx] <= s_data;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          r_win[r][c] <= w_win_next[r][c];
        end
      end
    end
  end

  // Output window register with hold-under-backpressure and event pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m_valid    <= 1'b0;
      r_m_window   <= '0;
      r_m_row      <= 16'd0;
      r_m_col      <= 16'd0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_frame_done <= w_done_p;
      r_cfg_err    <= w_cfg_err_p;
      if (start_frame) begin
        r_m_valid <= 1'b0;
      end else if (w_accept && w_emit) begin
        r_m_valid  <= 1'b1;
        r_m_window <= w_win_flat;
        r_m_row    <= r_row - K_M1;
        r_m_col    <= r_col - K_M1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef LB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles a window waits on the consumer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (start_frame) begin
      r_stall_cnt <= 32'd0;
    end else if (r_m_valid && !m_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
